sd_card_responder: RTL

- Card-side SD responder in single-bit SPI style: the counterpart of the host bridge.
- Receives 48-bit commands on MOSI and answers on MISO with R1 responses, read data blocks, and write data-response/busy tokens.
- Backs one 64-bit word per address with an external synchronous memory port.
- Used as the SD end of system simulations and as a synthesizable card model.

---
 rtl/sd_card_responder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_card_responder.sv
// sd_card_responder: card side of a single-bit SPI-style SD link.
// Receives 48-bit commands on MOSI and answers on MISO with an R1 byte. A
// good CMD17 returns a read block {0xFE, data[63:0], CRC16}. A good CMD24
// accepts a write block and answers with a data-response token followed by
// busy-low cycles. Each address backs one 64-bit word in an external
// synchronous memory.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   MOSI        host->card serial line, idle high, MSB first
//   MISO        card->host serial line, idle high, MSB first (registered)
//   mem_addr    word address for the current read or write
//   mem_ren     one-cycle read strobe; mem_rdata is expected one cycle later
//   mem_rdata   read data
//   mem_wen     one-cycle write strobe, qualified by mem_addr/mem_wdata
//   mem_wdata   write data
//   card_busy   high from the command start-bit sample until return to IDLE
//
// Build option: SD_CRC_CHECK_EN. When defined, the command CRC7 and the write
// CRC16 are checked. When undefined, both checks always pass. Read blocks
// always carry a computed CRC16.
module sd_card_responder #(
  parameter int RESP_GAP    = 8,   // >= 1
  parameter int DATA_GAP    = 8,   // >= 2
  parameter int BUSY_CYCLES = 16   // >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic [15:0] mem_addr,
  output logic        mem_ren,
  input  logic [63:0] mem_rdata,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic        card_busy
);

`ifdef SD_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  localparam int M1      = (RESP_GAP > 88) ? RESP_GAP : 88;
  localparam int M2      = (DATA_GAP > M1) ? DATA_GAP : M1;
  localparam int CNT_MAX = (BUSY_CYCLES > M2) ? BUSY_CYCLES : M2;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C1    = CW'(1);
  localparam logic [CW-1:0] C8    = CW'(8);
  localparam logic [CW-1:0] C47   = CW'(47);
  localparam logic [CW-1:0] C79   = CW'(79);
  localparam logic [CW-1:0] C88   = CW'(88);
  localparam logic [CW-1:0] RG    = CW'(RESP_GAP);
  localparam logic [CW-1:0] DG_M1 = CW'(DATA_GAP - 1);
  localparam logic [CW-1:0] BC    = CW'(BUSY_CYCLES);

  typedef enum logic [3:0] {
    IDLE, CMD_RX, RESP_WAIT, RESP_TX, RD_WAIT, RD_TX,
    WR_TOKEN, WR_RX, WR_RESP, WR_BUSY
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [46:0]   cmd_sr;   // command bits 47..1 once the end bit arrives
  logic [7:0]    r1_sr;    // outgoing R1 or data-response byte
  logic          cmd_ok;
  logic          cmd_rd;
  logic [15:0]   arg_lo;
  logic [87:0]   rd_sr;
  logic [78:0]   wr_sr;
  logic          wr_ok;

  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--)
      c = {c[5:0], 1'b0} ^ ({7{c[6] ^ d[i]}} & 7'h09);
    return c;
  endfunction

  function automatic logic [15:0] crc16_calc(input logic [63:0] d);
    logic [15:0] c;
    c = '0;
    for (int i = 63; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ({16{c[15] ^ d[i]}} & 16'h1021);
    return c;
  endfunction

  // The live MOSI bit completes both the command and the write block.
  logic [47:0] cmd_full;
  logic [79:0] wr_full;
  logic [87:0] rd_word;
  logic        crc7_ok, wr_crc_ok;
  logic [7:0]  r1_val;

  assign cmd_full  = {cmd_sr, MOSI};
  assign wr_full   = {wr_sr, MOSI};
  assign rd_word   = {8'hFE, mem_rdata, crc16_calc(mem_rdata)};
  assign crc7_ok   = !CRC_CHK || (crc7_calc(cmd_full[47:8]) == cmd_full[7:1]);
  assign wr_crc_ok = !CRC_CHK || (crc16_calc(wr_full[79:16]) == wr_full[15:0]);

  always_comb begin
    r1_val = 8'h00;
    if (!cmd_full[46] || !cmd_full[0] || !crc7_ok)
      r1_val = 8'h08;
    else if (cmd_full[45:40] != 6'd17 && cmd_full[45:40] != 6'd24)
      r1_val = 8'h04;
    else if (cmd_full[39:24] != 16'h0)
      r1_val = 8'h40;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sr    <= '0;
      r1_sr     <= '0;
      cmd_ok    <= 1'b0;
      cmd_rd    <= 1'b0;
      arg_lo    <= '0;
      rd_sr     <= '0;
      wr_sr     <= '0;
      wr_ok     <= 1'b0;
      MISO      <= 1'b1;
      mem_addr  <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      card_busy <= 1'b0;
    end else begin
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: if (!MOSI) begin
          state     <= CMD_RX;
          cnt       <= C1;
          cmd_sr    <= '0;          // start bit is 0
          card_busy <= 1'b1;
        end
        CMD_RX: begin
          cmd_sr <= {cmd_sr[45:0], MOSI};
          if (cnt == C47) begin
            r1_sr  <= r1_val;
            cmd_ok <= (r1_val == 8'h00);
            cmd_rd <= (cmd_full[45:40] == 6'd17);
            arg_lo <= cmd_full[23:8];
            state  <= RESP_WAIT;
            cnt    <= '0;
          end else cnt <= cnt + 1'b1;
        end
        RESP_WAIT: if (cnt == RG) begin
          MISO  <= r1_sr[7];
          r1_sr <= {r1_sr[6:0], 1'b1};
          state <= RESP_TX;
          cnt   <= C1;
        end else cnt <= cnt + 1'b1;
        RESP_TX: if (cnt == C8) begin
          MISO <= 1'b1;
          cnt  <= '0;
          if (!cmd_ok) begin
            state     <= IDLE;
            card_busy <= 1'b0;
          end else if (cmd_rd) begin
            state    <= RD_WAIT;
            mem_ren  <= 1'b1;
            mem_addr <= arg_lo;
          end else begin
            state    <= WR_TOKEN;
            mem_addr <= arg_lo;
          end
        end else begin
          MISO  <= r1_sr[7];
          r1_sr <= {r1_sr[6:0], 1'b1};
          cnt   <= cnt + 1'b1;
        end
        RD_WAIT: begin
          // Read data arrives on the second RD_WAIT edge. With DATA_GAP=2 that
          // edge also starts the token, whose MSB is always 1.
          if (cnt == C1) rd_sr <= rd_word;
          if (cnt == DG_M1) begin
            MISO  <= 1'b1;
            rd_sr <= (cnt == C1) ? {rd_word[86:0], 1'b1} : {rd_sr[86:0], 1'b1};
            state <= RD_TX;
            cnt   <= C1;
          end else cnt <= cnt + 1'b1;
        end
        RD_TX: if (cnt == C88) begin
          MISO      <= 1'b1;
          state     <= IDLE;
          card_busy <= 1'b0;
        end else begin
          MISO  <= rd_sr[87];
          rd_sr <= {rd_sr[86:0], 1'b1};
          cnt   <= cnt + 1'b1;
        end
        WR_TOKEN: if (!MOSI) begin
          state <= WR_RX;
          cnt   <= '0;
        end
        WR_RX: begin
          wr_sr <= {wr_sr[77:0], MOSI};
          if (cnt == C79) begin
            if (wr_crc_ok) mem_wdata <= wr_full[79:16];
            wr_ok <= wr_crc_ok;
            r1_sr <= wr_crc_ok ? 8'h05 : 8'h0B;
            state <= WR_RESP;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WR_RESP: if (cnt == C8) begin
          MISO    <= 1'b0;
          mem_wen <= wr_ok;
          state   <= WR_BUSY;
          cnt     <= C1;
        end else begin
          MISO  <= r1_sr[7];
          r1_sr <= {r1_sr[6:0], 1'b1};
          cnt   <= cnt + 1'b1;
        end
        WR_BUSY: if (cnt == BC) begin
          MISO      <= 1'b1;
          state     <= IDLE;
          card_busy <= 1'b0;
        end else begin
          MISO <= 1'b0;
          cnt  <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
